// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the 100BASE-T1 core (25 MHz domain): waits for PLL lock and the
// 33 MHz domain, then releases PHY, PCS and MAC resets in order with programmable delays.
module rst_seq_ctrl #(
   parameter logic [15:0] PHY_DLY   = 16'd250,
   parameter logic [15:0] PCS_DLY   = 16'd64,
   parameter logic [15:0] MAC_DLY   = 16'd32,
   parameter logic [15:0] SOFT_HOLD = 16'd16,
   parameter logic [15:0] LOCK_TO   = 16'd2500
) (
   input  logic sys_clk_25m,
   input  logic reset_n,
   input  logic pll_lock,
   input  logic rst_n_33m,
   input  logic soft_rst_req,
   output logic phy_rst_n,
   output logic pcs_rst_n,
   output logic mac_rst_n,
   output logic rst_busy,
   output logic rst_done,
   output logic soft_rst_ack,
   output logic lock_err
);

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT_LOCK,
      S_PHY_WAIT,
      S_PCS_WAIT,
      S_MAC_WAIT,
      S_RUN,
      S_SOFT
   } state_t;

   localparam logic [15:0] PHY_LAST  = PHY_DLY - 16'd1;
   localparam logic [15:0] PCS_LAST  = PCS_DLY - 16'd1;
   localparam logic [15:0] MAC_LAST  = MAC_DLY - 16'd1;
   localparam logic [15:0] SOFT_LAST = SOFT_HOLD - 16'd1;
   localparam logic [15:0] LOCK_LAST = LOCK_TO - 16'd1;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic        r_lock_meta, r_lock_s, r_r33_meta, r_r33_s;
   logic        r_phy_rst_n, r_pcs_rst_n, r_mac_rst_n;
   logic        r_rst_busy, r_rst_done, r_soft_rst_ack, r_lock_err;

   state_t      w_nxt;
   logic [15:0] w_cnt_nxt;
   logic        w_ok, w_ack_nxt, w_lock_err_nxt;
   logic        w_phy_nxt, w_pcs_nxt, w_mac_nxt;

   // Two-flop synchronisers for the asynchronous lock and 33 MHz reset status.
   always_ff @(posedge sys_clk_25m or negedge reset_n) begin
      if (!reset_n) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
         r_r33_meta  <= 1'b0;
         r_r33_s     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so each flop samples the previous stage's old value.
         r_lock_meta <= pll_lock;
         r_lock_s    <= r_lock_meta;
         r_r33_meta  <= rst_n_33m;
         r_r33_s     <= r_r33_meta;
      end
   end

   assign w_ok = r_lock_s & r_r33_s;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_nxt          = r_state;
      w_cnt_nxt      = r_cnt + 16'd1;
      w_ack_nxt      = 1'b0;
      w_lock_err_nxt = r_lock_err;
      unique case (r_state)
         S_HOLD:      w_nxt = S_WAIT_LOCK;
         S_WAIT_LOCK: begin
            if (w_ok) begin
               w_nxt = S_PHY_WAIT;
            end else if (r_cnt == LOCK_LAST) begin
               w_lock_err_nxt = 1'b1;
               w_cnt_nxt      = 16'd0;
            end
         end
         S_PHY_WAIT:  if (!w_ok) w_nxt = S_HOLD; else if (r_cnt == PHY_LAST) w_nxt = S_PCS_WAIT;
         S_PCS_WAIT:  if (!w_ok) w_nxt = S_HOLD; else if (r_cnt == PCS_LAST) w_nxt = S_MAC_WAIT;
         S_MAC_WAIT:  if (!w_ok) w_nxt = S_HOLD; else if (r_cnt == MAC_LAST) w_nxt = S_RUN;
         S_RUN: begin
            w_cnt_nxt = r_cnt;
            if (!w_ok)             w_nxt = S_HOLD;
            else if (soft_rst_req) w_nxt = S_SOFT;
         end
         S_SOFT: begin
            if (!w_ok) begin
               w_nxt = S_HOLD;
            end else if (r_cnt == SOFT_LAST) begin
               w_nxt     = S_WAIT_LOCK;
               w_ack_nxt = 1'b1;
            end
         end
         default:     w_nxt = S_HOLD;
      endcase
      if (w_nxt != r_state) w_cnt_nxt = 16'd0;

      // Outputs are decoded from the next state so they register together with it.
      w_phy_nxt = (w_nxt == S_PCS_WAIT) || (w_nxt == S_MAC_WAIT) || (w_nxt == S_RUN);
      w_pcs_nxt = (w_nxt == S_MAC_WAIT) || (w_nxt == S_RUN);
      w_mac_nxt = (w_nxt == S_RUN);
   end

   always_ff @(posedge sys_clk_25m or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_HOLD;
         r_cnt          <= 16'd0;
         r_phy_rst_n    <= 1'b0;
         r_pcs_rst_n    <= 1'b0;
         r_mac_rst_n    <= 1'b0;
         r_rst_busy     <= 1'b1;
         r_rst_done     <= 1'b0;
         r_soft_rst_ack <= 1'b0;
         r_lock_err     <= 1'b0;
      end else begin
         r_state        <= w_nxt;
         r_cnt          <= w_cnt_nxt;
         r_phy_rst_n    <= w_phy_nxt;
         r_pcs_rst_n    <= w_pcs_nxt;
         r_mac_rst_n    <= w_mac_nxt;
         r_rst_busy     <= !w_mac_nxt;
         r_rst_done     <= w_mac_nxt;
         r_soft_rst_ack <= w_ack_nxt;
         r_lock_err     <= w_lock_err_nxt;
      end
   end

   assign phy_rst_n    = r_phy_rst_n;
   assign pcs_rst_n    = r_pcs_rst_n;
   assign mac_rst_n    = r_mac_rst_n;
   assign rst_busy     = r_rst_busy;
   assign rst_done     = r_rst_done;
   assign soft_rst_ack = r_soft_rst_ack;
   assign lock_err     = r_lock_err;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a stage/age reference model pushes the expected output
// vector every edge; a negedge monitor pops and compares against the DUT.
module tb_rst_seq_ctrl;

   localparam logic [15:0] PHY_DLY   = 16'd4;
   localparam logic [15:0] PCS_DLY   = 16'd3;
   localparam logic [15:0] MAC_DLY   = 16'd2;
   localparam logic [15:0] SOFT_HOLD = 16'd5;
   localparam logic [15:0] LOCK_TO   = 16'd20;

   // Model stages, in release order.
   localparam int M_HOLD = 0, M_WAIT = 1, M_PHY = 2, M_PCS = 3, M_MAC = 4, M_RUN = 5, M_SOFT = 6;

   logic sys_clk_25m = 1'b0;
   logic reset_n, pll_lock, rst_n_33m, soft_rst_req;
   logic phy_rst_n, pcs_rst_n, mac_rst_n, rst_busy, rst_done, soft_rst_ack, lock_err;

   rst_seq_ctrl #(
      .PHY_DLY(PHY_DLY), .PCS_DLY(PCS_DLY), .MAC_DLY(MAC_DLY),
      .SOFT_HOLD(SOFT_HOLD), .LOCK_TO(LOCK_TO)
   ) dut (
      .sys_clk_25m (sys_clk_25m),
      .reset_n     (reset_n),
      .pll_lock    (pll_lock),
      .rst_n_33m   (rst_n_33m),
      .soft_rst_req(soft_rst_req),
      .phy_rst_n   (phy_rst_n),
      .pcs_rst_n   (pcs_rst_n),
      .mac_rst_n   (mac_rst_n),
      .rst_busy    (rst_busy),
      .rst_done    (rst_done),
      .soft_rst_ack(soft_rst_ack),
      .lock_err    (lock_err)
   );

   always #20 sys_clk_25m = ~sys_clk_25m;

   int n_checks = 0;
   int n_errors = 0;
   int dut_acks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         m_stage, m_age, m_edge;
   bit         m_lock_err, m_ack;
   bit         okq[$];
   logic [6:0] exp_q[$];

   function automatic int stage_delay(input int s);
      case (s)
         M_PHY:   return int'(PHY_DLY);
         M_PCS:   return int'(PCS_DLY);
         M_MAC:   return int'(MAC_DLY);
         M_SOFT:  return int'(SOFT_HOLD);
         default: return 0;
      endcase
   endfunction

   // {phy, pcs, mac, busy, done, ack, lock_err}; number of released blocks grows with stage.
   function automatic logic [6:0] model_vec();
      int released;
      released = (m_stage >= M_PCS && m_stage <= M_RUN) ? m_stage - M_PHY : 0;
      return {released >= 1, released >= 2, released >= 3,
              m_stage != M_RUN, m_stage == M_RUN, m_ack, m_lock_err};
   endfunction

   function automatic void model_reset();
      m_stage    = M_HOLD;
      m_age      = 0;
      m_edge     = 0;
      m_lock_err = 1'b0;
      m_ack      = 1'b0;
      okq.delete();
      okq.push_back(1'b0);
      okq.push_back(1'b0);
   endfunction

   function automatic void model_step();
      bit ok;
      int nxt;
      m_edge++;
      ok = okq.pop_front();
      okq.push_back(pll_lock & rst_n_33m);
      m_ack = 1'b0;
      nxt   = m_stage;
      if (m_stage == M_HOLD) begin
         nxt = M_WAIT;
      end else if (m_stage == M_WAIT) begin
         if (ok) nxt = M_PHY;
         else if (m_age == int'(LOCK_TO) - 1) begin
            m_lock_err = 1'b1;
            m_age      = -1;
         end
      end else if (!ok) begin
         nxt = M_HOLD;
      end else if (m_stage == M_RUN) begin
         if (soft_rst_req) nxt = M_SOFT;
      end else if (m_age == stage_delay(m_stage) - 1) begin
         nxt   = (m_stage == M_SOFT) ? M_WAIT : m_stage + 1;
         m_ack = (m_stage == M_SOFT);
      end
      if (nxt != m_stage) m_age = 0;
      else                m_age++;
      m_stage = nxt;
   endfunction

   always @(posedge sys_clk_25m or negedge reset_n) begin
      if (!reset_n) begin
         model_reset();
         exp_q.delete();
      end else begin
         model_step();
      end
      exp_q.push_back(model_vec());
   end

   // ---------------- monitor ----------------
   always @(negedge sys_clk_25m) begin
      logic [6:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("outs{phy,pcs,mac,busy,done,ack,err}",
               {25'd0, phy_rst_n, pcs_rst_n, mac_rst_n, rst_busy, rst_done, soft_rst_ack, lock_err},
               {25'd0, e});
      end
      if (soft_rst_ack === 1'b1) dut_acks++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge sys_clk_25m);
      #5;
   endtask

   task automatic wait_stage(input int s, input int budget, input string name);
      for (int i = 0; i < budget && m_stage != s; i++) tick();
      if (m_stage != s) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: stage %0d not reached within %0d cycles", name, s, budget);
      end
   endtask

   task automatic wait_output_edge(input bit use_err, input int budget, input string name,
                                   input int exp_edge);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge sys_clk_25m);
         found = use_err ? (lock_err === 1'b1) : (rst_done === 1'b1);
      end
      check(name, found ? m_edge : -1, exp_edge);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks0;
      int lock_off;
      reset_n      = 1'b0;
      pll_lock     = 1'b1;
      rst_n_33m    = 1'b1;
      soft_rst_req = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;

      // Lock present throughout: full release completes at edge 12.
      wait_output_edge(1'b0, 40, "first rst_done edge", 12);
      repeat (3) tick();

      // No lock after reset: timeout flag at edge 21, then normal sequence.
      reset_n  = 1'b0;
      pll_lock = 1'b0;
      tick();
      reset_n = 1'b1;
      wait_output_edge(1'b1, 60, "lock_err edge", 21);
      repeat (7) tick();
      pll_lock = 1'b1;
      wait_stage(M_RUN, 60, "run after lock");
      repeat (2) tick();

      // One-cycle soft reset in RUN: exactly one ack, then re-sequence.
      acks0        = dut_acks;
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      wait_stage(M_RUN, 60, "run after soft");
      check("soft ack count", dut_acks - acks0, 1);

      // Drop 33 MHz reset status in PCS_WAIT.
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      wait_stage(M_PCS, 60, "pcs_wait");
      rst_n_33m = 1'b0;
      repeat (4) tick();
      rst_n_33m = 1'b1;
      wait_stage(M_RUN, 60, "run after r33 drop");
      repeat (2) tick();

      // Lock loss seen by the FSM in the same cycle as a soft request; soft in MAC_WAIT ignored.
      acks0    = dut_acks;
      pll_lock = 1'b0;
      tick();
      tick();
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      repeat (2) tick();
      pll_lock = 1'b1;
      wait_stage(M_MAC, 60, "mac_wait");
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      wait_stage(M_RUN, 20, "run after ignored soft");
      repeat (3) tick();
      check("no ack on aborted/ignored soft", dut_acks - acks0, 0);

      // Asynchronous reset in MAC_WAIT clears everything before any clock edge.
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      wait_stage(M_MAC, 60, "mac_wait before reset");
      reset_n = 1'b0;
      #1;
      check("async reset outs", {phy_rst_n, pcs_rst_n, mac_rst_n, rst_busy, rst_done,
                                 soft_rst_ack, lock_err}, 7'b0001000);
      tick();
      reset_n = 1'b1;

      // Randomised traffic: short and long lock drops, 33 MHz glitches, soft requests, resets.
      lock_off = 0;
      for (int i = 0; i < 1500; i++) begin
         if (lock_off == 0 && ($urandom % 300) == 0) lock_off = $urandom_range(5, 40);
         pll_lock     = (lock_off == 0) && (($urandom % 60) != 0);
         if (lock_off > 0) lock_off--;
         rst_n_33m    = ($urandom % 70) != 0;
         soft_rst_req = ($urandom % 10) == 0;
         reset_n      = ($urandom % 500) != 0;
         tick();
      end
      reset_n      = 1'b1;
      pll_lock     = 1'b1;
      rst_n_33m    = 1'b1;
      soft_rst_req = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
